// File: rtl/or16_bist_pkg.sv
// Shared types and constants for the OR16 built-in self-test sequencer.
// Holds the state encoding, the LFSR tap mask and the four directed operand pairs.
package or16_bist_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  localparam logic [15:0] LFSR_TAP     = 16'hB400;
  localparam logic [15:0] NO_FAIL      = 16'hFFFF;
  localparam logic [15:0] NUM_DIRECTED = 16'd4;

  // Directed {a,b} pairs, index 0 in the low word: (0,0) (1,0) (0,1) (1,1)
  localparam logic [3:0][31:0] DIR_VEC = {32'h0001_0001, 32'h0000_0001,
                                          32'h0001_0000, 32'h0000_0000};

endpackage

// File: rtl/or16_bist_lfsr16.sv
// One combinational step of the 16-bit Galois right-shift LFSR.
module lfsr16
  import or16_bist_pkg::*;
(
  input  logic [15:0] cur,
  output logic [15:0] nxt
);

  assign nxt = cur[0] ? ((cur >> 1) ^ LFSR_TAP) : (cur >> 1);

endmodule

// File: rtl/or16_bist.sv
// Vector sequencer that drives an OR16 gate, waits SETTLE cycles, and judges
// each result against an inline a|b, counting mismatches and the first failure.
module or16_bist
  import or16_bist_pkg::*;
#(
  parameter int          SETTLE      = 1,
  parameter int          NUM_VECTORS = 64,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dut_out,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic [15:0] fail_index
);

  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] CNT_END  = 16'(SETTLE - 1);

  state_t      state, state_nxt;
  logic [15:0] lfsr, lfsr_nxt, idx, idx_nxt, cnt, cnt_nxt, nidx;
  logic [15:0] a_nxt, b_nxt, fi_nxt;
  logic [7:0]  err_nxt, err_inc;
  logic        busy_nxt, done_nxt, pass_nxt, mismatch;

  // Two chained steps: chain[1] becomes b, chain[2] is the state after the pair
  logic [2:0][15:0] chain;
  assign chain[0] = lfsr;

  for (genvar g = 0; g < 2; g++) begin : g_step
    lfsr16 u_step (.cur(chain[g]), .nxt(chain[g+1]));
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    err_nxt   = err_count;
    fi_nxt    = fail_index;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    // Expected value is computed here, never from a second OR16 that could share the fault
    mismatch  = dut_out != (a | b);
    err_inc   = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    nidx      = idx + 16'd1;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt      = S_SETTLE;
          {a_nxt, b_nxt} = DIR_VEC[0];
          lfsr_nxt       = SEED;
          idx_nxt        = '0;
          cnt_nxt        = '0;
          err_nxt        = '0;
          fi_nxt         = NO_FAIL;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          pass_nxt       = 1'b0;
        end
      end
      S_SETTLE: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == CNT_END) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (mismatch) begin
          err_nxt = err_inc;
          if (fail_index == NO_FAIL) fi_nxt = idx;
        end
        if (idx == LAST_IDX) begin
          state_nxt = S_DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (err_nxt == 8'd0);
        end else begin
          state_nxt = S_SETTLE;
          cnt_nxt   = '0;
          idx_nxt   = nidx;
          if (nidx < NUM_DIRECTED) begin
            {a_nxt, b_nxt} = DIR_VEC[nidx[1:0]];
          end else begin
            a_nxt    = lfsr;
            b_nxt    = chain[1];
            lfsr_nxt = chain[2];
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lfsr       <= SEED;
      idx        <= '0;
      cnt        <= '0;
      a          <= '0;
      b          <= '0;
      err_count  <= '0;
      fail_index <= NO_FAIL;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      err_count  <= err_nxt;
      fail_index <= fi_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_or16_bist.sv
// Scoreboard bench for or16_bist: a reference model queues expected vectors and
// results per run, and a negedge monitor pops and compares as the DUT presents them.
module tb_or16_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0_n, rst1_n, start0, start1;
  logic [15:0] a0, b0, d0, fi0, a1, b1, d1, fi1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0]  ec0, ec1;
  int          mode0 = 0;

  typedef struct packed {logic [15:0] a; logic [15:0] b;} tv_t;
  typedef struct packed {logic pass; logic [7:0] err; logic [15:0] fi;} res_t;

  tv_t  vq0[$], vq1[$];
  res_t rq0[$], rq1[$];
  int   tests = 0, fails = 0;
  int   cyc[2] = '{0, 0}, active[2] = '{0, 0}, runs[2] = '{0, 0};
  logic pb[2] = '{1'b0, 1'b0};
  tv_t  cur[2];

  // Gate models: 0 good, 1 out[0] stuck at 0, 2 inverted
  function automatic logic [15:0] gate(input int m, input logic [15:0] x, input logic [15:0] y);
    case (m)
      1:       return (x | y) & 16'hFFFE;
      2:       return ~(x | y);
      default: return x | y;
    endcase
  endfunction

  always_comb begin
    d0 = gate(mode0, a0, b0);
    d1 = gate(2, a1, b1);
  end

  or16_bist u_dut0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .dut_out(d0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(ec0), .fail_index(fi0));

  or16_bist #(.NUM_VECTORS(300)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .dut_out(d1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(ec1), .fail_index(fi1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Reference: build the whole vector list and final verdict of one run
  task automatic push_run(input int i, input int n, input int m);
    logic [15:0] x = 16'hACE1;
    logic [15:0] fi = 16'hFFFF;
    int          err = 0;
    tv_t         v;
    res_t        r;
    for (int k = 0; k < n; k++) begin
      if (k < 4) begin
        v.a = 16'(k % 2);
        v.b = 16'(k / 2);
      end else begin
        v.a = x; x = step(x);
        v.b = x; x = step(x);
      end
      if (gate(m, v.a, v.b) !== (v.a | v.b)) begin
        if (fi == 16'hFFFF) fi = 16'(k);
        err++;
      end
      if (i == 0) vq0.push_back(v); else vq1.push_back(v);
    end
    r.err  = (err > 255) ? 8'hFF : 8'(err);
    r.fi   = fi;
    r.pass = (err == 0);
    if (i == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic mon(input int i, input logic rn, input logic bz, input logic dn, input logic ps,
                     input logic [7:0] ec, input logic [15:0] fi, input logic [15:0] a,
                     input logic [15:0] b, input int n);
    tv_t  v;
    res_t r;
    if (!rn) begin
      active[i] = 0;
      pb[i]     = 1'b0;
      return;
    end
    if (bz && !pb[i]) begin
      active[i] = 1;
      cyc[i]    = 0;
      chk($sformatf("start_clear%0d", i), 64'({dn, ec, fi}), 64'({1'b0, 8'h00, 16'hFFFF}));
    end else if (active[i] != 0) begin
      cyc[i]++;
    end
    pb[i] = bz;
    if (active[i] == 0) return;
    if (bz && (cyc[i] % 2 == 0)) begin
      if ((i == 0 && vq0.size() == 0) || (i == 1 && vq1.size() == 0)) begin
        tests++; fails++;
        $display("FAIL unexpected_vec%0d: got a=%0h b=%0h expected none", i, a, b);
        active[i] = 0;
        return;
      end
      v = (i == 0) ? vq0.pop_front() : vq1.pop_front();
      cur[i] = v;
      chk($sformatf("vec%0d_%0d", i, cyc[i] / 2), 64'({a, b}), 64'({v.a, v.b}));
    end else begin
      chk($sformatf("hold%0d_%0d", i, cyc[i]), 64'({a, b}), 64'({cur[i].a, cur[i].b}));
    end
    if (dn) begin
      if ((i == 0 && rq0.size() == 0) || (i == 1 && rq1.size() == 0)) begin
        tests++; fails++;
        $display("FAIL unexpected_done%0d: got done expected none", i);
      end else begin
        r = (i == 0) ? rq0.pop_front() : rq1.pop_front();
        chk($sformatf("done_cycle%0d", i), 64'(cyc[i]), 64'(n * 2));
        chk($sformatf("result%0d", i), 64'({ps, ec, fi}), 64'({r.pass, r.err, r.fi}));
      end
      runs[i]++;
      active[i] = 0;
    end else if (!bz) begin
      tests++; fails++;
      $display("FAIL busy_drop%0d: got busy=0 expected busy or done", i);
      active[i] = 0;
    end else if (cyc[i] > 2 * n + 2) begin
      tests++; fails++;
      $display("FAIL run_timeout%0d: got %0d cycles expected %0d", i, cyc[i], 2 * n);
      active[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst0_n, busy0, done0, pass0, ec0, fi0, a0, b0, 64);
    mon(1, rst1_n, busy1, done1, pass1, ec1, fi1, a1, b1, 300);
  end

  task automatic wait_run(input int i, input int target, input int budget);
    int t = 0;
    while (runs[i] < target && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    tests++;
    if (runs[i] < target) begin
      fails++;
      $display("FAIL wait_run%0d: got %0d runs expected %0d", i, runs[i], target);
    end
  endtask

  task automatic pulse0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic run0(input int m);
    mode0 = m;
    repeat ($urandom_range(0, 4)) @(negedge clk);
    push_run(0, 64, m);
    pulse0();
    wait_run(0, runs[0] + 1, 200);
  endtask

  localparam logic [58:0] RST_VAL = {32'h0, 3'b000, 8'h00, 16'hFFFF};

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_low0", 64'({a0, b0, busy0, done0, pass0, ec0, fi0}), 64'(RST_VAL));
    rst0_n = 1'b1; rst1_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("idle0_%0d", k), 64'({a0, b0, busy0, done0, pass0, ec0, fi0}), 64'(RST_VAL));
      chk($sformatf("idle1_%0d", k), 64'({a1, b1, busy1, done1, pass1, ec1, fi1}), 64'(RST_VAL));
    end

    run0(0);
    run0(1);

    // start held high across a whole run, then through the first DONE cycle
    mode0 = 1;
    push_run(0, 64, 1);
    push_run(0, 64, 1);
    start0 = 1'b1;
    wait_run(0, runs[0] + 1, 200);
    @(negedge clk);
    start0 = 1'b0;
    wait_run(0, runs[0] + 1, 200);

    // asynchronous reset in the middle of vector 10
    mode0 = 0;
    push_run(0, 64, 0);
    pulse0();
    for (int t = 0; t < 100 && !(active[0] != 0 && cyc[0] == 20); t++) begin
      @(negedge clk); #1;
    end
    #2 rst0_n = 1'b0;
    #1 chk("async_reset", 64'({a0, b0, busy0, done0, pass0, ec0, fi0}), 64'(RST_VAL));
    vq0.delete();
    rq0.delete();
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    run0(0);

    for (int k = 0; k < 3; k++) run0($urandom_range(0, 2));

    // long run against an inverting gate: saturation and first-index capture
    push_run(1, 300, 2);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_run(1, runs[1] + 1, 700);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
